// File: rtl/alarm_timer_s_axi.sv
// -----------------------------------------------------------------------------
// alarm_timer_s_axi
//
// Metal-detect alarm timer behind an AXI4-Lite slave. A rising edge on
// detect_in (while enabled) is counted, latches a sticky event flag and
// starts an alarm window of DURATION ticks. Each tick is PRESCALE+1 clocks.
// The window can optionally be restarted by later edges (RETRIG).
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | alarm off, waiting for a counted detect edge
// ACTIVE| alarm on, REMAIN ticks left, prescale counter running
//
// Register map (word index = ADDR[4:2]):
//   0 CTRL      rw  bit0 EN, bit1 RETRIG, bit2 IRQ_EN (all 32 bits stored)
//   1 DURATION  rw  alarm length in ticks (0 = count edge only)
//   2 PRESCALE  rw  tick period minus one
//   3 SCRATCH   rw
//   4 STATUS    ro  bit0 ACTIVE, bit1 EVT (write 1 to bit1 clears)
//   5 REMAIN    ro  ticks left in the current window
//   6 EVCOUNT   ro  counted edges, wraps
//   7 reserved  reads 0
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN    clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*              AXI4-Lite write address/data/response
//   S_AXI_AR*/R*                 AXI4-Lite read address/data
//   detect_in                    synchronous detect level
//   alarm_out                    registered alarm drive (state == ACTIVE)
//   irq                          registered level interrupt (IRQ_EN & EVT)
// -----------------------------------------------------------------------------
module alarm_timer_s_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            detect_in,
    output logic                            alarm_out,
    output logic                            irq
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // AXI handshake registers
    logic          r_awready;
    logic          r_bvalid;
    logic          r_arready;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    // Register file
    logic [DW-1:0] r_ctrl;
    logic [DW-1:0] r_duration;
    logic [DW-1:0] r_prescale;
    logic [DW-1:0] r_scratch;
    logic          r_evt;
    logic [31:0]   r_evcount;

    // Timer
    state_t        r_state;
    logic [DW-1:0] r_remain;
    logic [DW-1:0] r_psc;
    logic          r_detect_d;
    logic          r_alarm;
    logic          r_irq;

    logic          w_wr_fire;
    logic          w_rd_fire;
    logic [2:0]    w_wr_idx;
    logic [2:0]    w_rd_idx;
    logic [7:0]    w_wr_sel;
    logic          w_edge;
    logic          w_w1c;
    logic          w_evt_nxt;
    logic [DW-1:0] w_ctrl_nxt;
    logic [DW-1:0] w_rd_mux;
    state_t        w_state_nxt;
    logic [DW-1:0] w_remain_nxt;
    logic [DW-1:0] w_psc_nxt;
    logic          w_unused_ok;

    function automatic logic [DW-1:0] f_merge(
        input logic [DW-1:0] old_val,
        input logic [DW-1:0] wdata,
        input logic [NB-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

    assign w_unused_ok = ^{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Ready is only raised with both channels valid, so the data beat and the
    // address are taken in the same cycle the ready pulse is high.
    assign w_wr_fire = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_fire = r_arready & S_AXI_ARVALID;
    assign w_wr_idx  = S_AXI_AWADDR[4:2];
    assign w_rd_idx  = S_AXI_ARADDR[4:2];
    assign w_wr_sel  = w_wr_fire ? (8'b1 << w_wr_idx) : 8'b0;

    assign w_edge    = detect_in & ~r_detect_d & r_ctrl[0];
    assign w_w1c     = w_wr_sel[4] & S_AXI_WDATA[1] & S_AXI_WSTRB[0];
    // A new event wins over a simultaneous clear.
    assign w_evt_nxt = w_edge | (r_evt & ~w_w1c);
    assign w_ctrl_nxt = w_wr_sel[0] ? f_merge(r_ctrl, S_AXI_WDATA, S_AXI_WSTRB) : r_ctrl;

    always_comb begin
        w_rd_mux = '0;
        case (w_rd_idx)
            3'd0:    w_rd_mux = r_ctrl;
            3'd1:    w_rd_mux = r_duration;
            3'd2:    w_rd_mux = r_prescale;
            3'd3:    w_rd_mux = r_scratch;
            3'd4:    w_rd_mux = {{(DW-2){1'b0}}, r_evt, (r_state == ST_ACTIVE)};
            3'd5:    w_rd_mux = r_remain;
            3'd6:    w_rd_mux = r_evcount;
            default: w_rd_mux = '0;
        endcase
    end

    // Timer next-state. The prescale compare uses the live PRESCALE value,
    // while DURATION is only sampled when the window is (re)loaded.
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_psc_nxt    = r_psc;
        if (!r_ctrl[0]) begin
            w_state_nxt  = ST_IDLE;
            w_remain_nxt = '0;
            w_psc_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_edge && (r_duration != '0)) begin
                        w_state_nxt  = ST_ACTIVE;
                        w_remain_nxt = r_duration;
                        w_psc_nxt    = '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_edge && r_ctrl[1]) begin
                        w_remain_nxt = r_duration;
                        w_psc_nxt    = '0;
                        if (r_duration == '0) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (r_psc == r_prescale) begin
                        w_psc_nxt    = '0;
                        w_remain_nxt = r_remain - {{(DW-1){1'b0}}, 1'b1};
                        if (r_remain <= {{(DW-1){1'b0}}, 1'b1}) begin
                            w_state_nxt  = ST_IDLE;
                            w_remain_nxt = '0;
                        end
                    end else begin
                        w_psc_nxt = r_psc + {{(DW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_remain_nxt = '0;
                    w_psc_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_ctrl     <= '0;
            r_duration <= '0;
            r_prescale <= '0;
            r_scratch  <= '0;
            r_evt      <= 1'b0;
            r_evcount  <= '0;
            r_state    <= ST_IDLE;
            r_remain   <= '0;
            r_psc      <= '0;
            r_detect_d <= 1'b0;
            r_alarm    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_awready <= ~r_awready & S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end

            r_arready <= ~r_arready & S_AXI_ARVALID & ~r_rvalid;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end

            r_ctrl <= w_ctrl_nxt;
            if (w_wr_sel[1]) r_duration <= f_merge(r_duration, S_AXI_WDATA, S_AXI_WSTRB);
            if (w_wr_sel[2]) r_prescale <= f_merge(r_prescale, S_AXI_WDATA, S_AXI_WSTRB);
            if (w_wr_sel[3]) r_scratch  <= f_merge(r_scratch, S_AXI_WDATA, S_AXI_WSTRB);

            r_evt <= w_evt_nxt;
            if (w_edge) begin
                r_evcount <= r_evcount + 32'd1;
            end

            r_detect_d <= detect_in;
            r_state    <= w_state_nxt;
            r_remain   <= w_remain_nxt;
            r_psc      <= w_psc_nxt;
            r_alarm    <= (w_state_nxt == ST_ACTIVE);
            r_irq      <= w_ctrl_nxt[2] & w_evt_nxt;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign alarm_out     = r_alarm;
    assign irq           = r_irq;

endmodule

// File: tb/tb_alarm_timer_s_axi.sv
// -----------------------------------------------------------------------------
// Bench for alarm_timer_s_axi: directed register/timer/irq scenarios plus
// randomized alarm windows checked against an arithmetic model of the alarm
// length, event count and sticky flag.
// -----------------------------------------------------------------------------
module tb_alarm_timer_s_axi;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        detect_in;
    logic        alarm_out;
    logic        irq;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state
    logic [31:0] m_reg [4];
    logic [31:0] m_evc;
    logic        m_evt;

    always #5 clk = ~clk;

    alarm_timer_s_axi dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .detect_in     (detect_in),
        .alarm_out     (alarm_out),
        .irq           (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Alarm cycles for a first edge at t=0 and optional second edge at t=g.
    // One window lasts L = d*(p+1) cycles; a second edge inside the window
    // extends it to g+L only when retriggering is on.
    function automatic int exp_alarm(input int d, input int p, input bit retrig, input int g);
        int len;
        len = d * (p + 1);
        if (d == 0) return 0;
        if (g < 0) return len;
        if (g <= len) return retrig ? g + len : len;
        return 2 * len;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Tasks start and end at 1 time unit after a rising edge.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, input bit det);
        bit ok;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        bready = (hold == 0);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        check("aw_handshake", {31'b0, ok}, 32'd1);
        check("wready_with_awready", {31'b0, wready}, 32'd1);
        if (det) detect_in = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; detect_in = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1'b1; break; end
        end
        check("bvalid_seen", {31'b0, ok}, 32'd1);
        check("awready_one_cycle", {31'b0, awready}, 32'd0);
        check("bresp", {30'b0, bresp}, 32'd0);
        if (hold > 0) begin
            awvalid = 1'b1; wvalid = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                @(negedge clk);
                check("bvalid_held", {31'b0, bvalid}, 32'd1);
                check("no_new_awready", {31'b0, awready}, 32'd0);
            end
            awvalid = 1'b0; wvalid = 1'b0;
            bready = 1'b1;
        end
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic read_start(input logic [4:0] a);
        bit ok;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        check("ar_handshake", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (rvalid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("rvalid_seen", {31'b0, ok}, 32'd1);
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] exp, input int rdly,
                            input string tag);
        read_start(a);
        check(tag, rdata, exp);
        check("rresp", {30'b0, rresp}, 32'd0);
        for (int k = 0; k < rdly; k++) begin
            @(posedge clk); #1;
            check("rdata_held", rdata, exp);
            check("rvalid_held", {31'b0, rvalid}, 32'd1);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic run_pattern(input int g, input int window, output int cnt, output int first_hi);
        cnt = 0; first_hi = -1;
        for (int i = 0; i < window; i++) begin
            detect_in = (i == 0) || (i == g);
            @(negedge clk);
            if (alarm_out) begin
                cnt++;
                if (first_hi < 0) first_hi = i;
            end
            @(posedge clk); #1;
        end
        detect_in = 1'b0;
    endtask

    task automatic pulse();
        detect_in = 1'b1;
        @(posedge clk); #1;
        detect_in = 1'b0;
    endtask

    task automatic wr_model(input int idx, input logic [31:0] d, input logic [3:0] s);
        axi_write(5'(idx * 4), d, s, 0, 1'b0);
        if (idx < 4) m_reg[idx] = merge(m_reg[idx], d, s);
    endtask

    task automatic timer_case(input string tag, input int d, input int p, input logic [31:0] ctrl,
                              input int g);
        int cnt, first_hi, e_cnt;
        wr_model(1, d, 4'hF);
        wr_model(2, p, 4'hF);
        wr_model(0, ctrl, 4'hF);
        run_pattern(g, ((g > 0) ? g : 0) + 2 * d * (p + 1) + 6, cnt, first_hi);
        e_cnt = exp_alarm(d, p, ctrl[1], g);
        m_evc = m_evc + ((g > 0) ? 32'd2 : 32'd1);
        m_evt = 1'b1;
        check({tag, "_alarm_len"}, cnt, e_cnt);
        check({tag, "_alarm_start"}, first_hi, (e_cnt == 0) ? -1 : 1);
        check({tag, "_irq"}, {31'b0, irq}, {31'b0, ctrl[2] & m_evt});
        axi_read(5'h18, m_evc, 0, {tag, "_evcount"});
        axi_read(5'h10, {30'b0, m_evt, 1'b0}, 0, {tag, "_status"});
        axi_read(5'h14, 32'd0, 0, {tag, "_remain"});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [31:0] d, s, c;
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        detect_in = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_evc = '0; m_evt = 1'b0;

        idle(3);
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_bvalid", {31'b0, bvalid}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_alarm", {31'b0, alarm_out}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        aresetn = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 32'd0, 0, "rst_reg");

        // Plain read-back of the rw registers, one read with a stalled RREADY
        for (int i = 0; i < 4; i++) wr_model(i, i + 1, 4'hF);
        for (int i = 0; i < 4; i++) axi_read(5'(i * 4), m_reg[i], (i == 3) ? 3 : 0, "rw_readback");

        // Partial strobe into SCRATCH with a long-stalled BREADY
        wr_model(3, 32'd0, 4'hF);
        axi_write(5'h0C, 32'hAABB_CCDD, 4'b0010, 5, 1'b0);
        m_reg[3] = merge(m_reg[3], 32'hAABB_CCDD, 4'b0010);
        axi_read(5'h0C, 32'h0000_CC00, 0, "scratch_strb");

        // Directed timer windows
        timer_case("single", 3, 1, 32'h1, -1);
        timer_case("retrig", 4, 0, 32'h3, 2);
        timer_case("noretrig", 4, 0, 32'h1, 2);
        timer_case("dur0", 0, 2, 32'h1, -1);

        // Interrupt set, clear and clear-vs-new-event collision
        axi_write(5'h10, 32'h2, 4'h1, 0, 1'b0); m_evt = 1'b0;
        wr_model(1, 2, 4'hF);
        wr_model(2, 0, 4'hF);
        wr_model(0, 32'h5, 4'hF);
        check("irq_clear_before", {31'b0, irq}, 32'd0);
        pulse(); m_evc++; m_evt = 1'b1;
        check("irq_set", {31'b0, irq}, 32'd1);
        idle(5);
        axi_write(5'h10, 32'h2, 4'h1, 0, 1'b0); m_evt = 1'b0;
        check("irq_w1c", {31'b0, irq}, 32'd0);
        axi_write(5'h10, 32'h2, 4'h1, 0, 1'b1); m_evc++; m_evt = 1'b1;
        check("irq_w1c_collide", {31'b0, irq}, 32'd1);
        idle(8);
        axi_read(5'h10, 32'h2, 0, "status_collide");
        axi_read(5'h18, m_evc, 0, "evcount_collide");

        // Randomized SCRATCH strobes
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            s = $urandom_range(1, 15);
            wr_model(3, d, s[3:0]);
            axi_read(5'h0C, m_reg[3], $urandom_range(0, 2), "rand_scratch");
        end

        // Randomized alarm windows
        for (int i = 0; i < 12; i++) begin
            int dd, pp, gg;
            dd = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6);
            pp = $urandom_range(0, 3);
            c  = ($urandom & 32'hFFFF_FFF8) | {29'b0, 1'($urandom), 1'($urandom), 1'b1};
            gg = ($urandom_range(0, 1) == 1) ? $urandom_range(2, dd * (pp + 1) + 4) : -1;
            timer_case("rand", dd, pp, c, gg);
            axi_read(5'h00, m_reg[0], 0, "rand_ctrl");
            if ($urandom_range(0, 1) == 1) begin
                axi_write(5'h10, 32'h2, 4'h1, 0, 1'b0);
                m_evt = 1'b0;
                check("rand_irq_after_w1c", {31'b0, irq}, 32'd0);
            end
        end

        // Read-only and reserved slots ignore writes
        axi_write(5'h14, $urandom, 4'hF, 0, 1'b0);
        axi_write(5'h18, $urandom, 4'hF, 0, 1'b0);
        axi_write(5'h1C, $urandom, 4'hF, 0, 1'b0);
        axi_read(5'h14, 32'd0, 0, "ro_remain");
        axi_read(5'h18, m_evc, 0, "ro_evcount");
        axi_read(5'h1C, 32'd0, 0, "ro_reserved");

        // Disabling mid-window stops the alarm and clears REMAIN
        wr_model(1, 100, 4'hF);
        wr_model(2, 0, 4'hF);
        wr_model(0, 32'h1, 4'hF);
        pulse(); m_evc++; m_evt = 1'b1;
        idle(3);
        check("en_clear_alarm_before", {31'b0, alarm_out}, 32'd1);
        wr_model(0, 32'h0, 4'hF);
        check("en_clear_alarm_after", {31'b0, alarm_out}, 32'd0);
        axi_read(5'h14, 32'd0, 0, "en_clear_remain");
        axi_read(5'h10, {30'b0, m_evt, 1'b0}, 0, "en_clear_status");

        // Reset while the alarm runs and a read response is pending
        wr_model(1, 200, 4'hF);
        wr_model(0, 32'h1, 4'hF);
        pulse(); m_evc++; m_evt = 1'b1;
        read_start(5'h10);
        check("pending_status", rdata, {30'b0, m_evt, 1'b1});
        aresetn = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_alarm", {31'b0, alarm_out}, 32'd0);
        check("rst_mid_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_mid_irq", {31'b0, irq}, 32'd0);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_evc = '0; m_evt = 1'b0;
        idle(2);
        check("rst_no_late_rvalid", {31'b0, rvalid}, 32'd0);
        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 32'd0, 0, "post_rst_reg");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
